// File: rtl/pce_pad_scanner.sv
// -----------------------------------------------------------------------------
// pce_pad_scanner
//
// Console-side scanner for the PC Engine joypad port. It drives CLR and SEL
// toward a single pad or a 5-port multitap and reads one 8-bit RS21LDRU byte
// per port, two nibbles at a time. Bytes are collected in a shadow buffer and
// published on PAD1..PAD5 together in a single COMMIT cycle, so the CPU side
// never sees a partially updated frame.
//
// Parameters:
//   SETTLE     cycles each CLR/SEL level is held before D_IN is sampled (1..255)
//   NUM_PORTS  ports scanned per frame (1..5); unscanned PADn read 8'hFF
//
// Ports:
//   CLK        system clock, rising edge
//   nRESET     asynchronous active-low reset
//   START      scan request, level-sampled only while idle
//   BUSY       high while a scan is in progress
//   DONE       one-cycle pulse when a new frame is committed
//   CLR        pad/multitap clear line
//   SEL        nibble select: 1 = LDRU (bits 3:0), 0 = RS21 (bits 7:4)
//   D_IN       nibble from pad/multitap, active-low
//   PAD1..PAD5 committed bytes, RS21LDRU, active-low
// -----------------------------------------------------------------------------
module pce_pad_scanner #(
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned NUM_PORTS = 5
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       CLR,
    output logic       SEL,
    input  logic [3:0] D_IN,
    output logic [7:0] PAD1,
    output logic [7:0] PAD2,
    output logic [7:0] PAD3,
    output logic [7:0] PAD4,
    output logic [7:0] PAD5
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR_HI = 3'd1,
        CLR_LO = 3'd2,
        RD_LO  = 3'd3,
        RD_HI  = 3'd4,
        COMMIT = 3'd5
    } state_t;

    // Counter runs SETTLE-1 .. 0, so a phase entered at edge e ends at e+SETTLE.
    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);
    localparam logic [2:0] LAST_PORT     = 3'(NUM_PORTS);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic [2:0] port_r;
    logic [2:0] port_s;
    logic       clr_r;
    logic       clr_s;
    logic       sel_r;
    logic       sel_s;
    logic       busy_r;
    logic       busy_s;
    logic       done_r;
    logic       done_s;
    logic       cap_lo_s;
    logic       cap_hi_s;
    logic       commit_s;
    logic       settled_s;
    logic [2:0] slot_s;
    logic [7:0] shadow_r [5];
    logic [7:0] pad_r    [5];

    assign settled_s = (cnt_r == 8'd0);
    // Port index is 1-based; shadow slots are 0-based.
    assign slot_s    = port_r - 3'd1;

    // Next-state, next-output and capture-strobe decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = settled_s ? 8'd0 : (cnt_r - 8'd1);
        port_s   = port_r;
        clr_s    = clr_r;
        sel_s    = sel_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        cap_lo_s = 1'b0;
        cap_hi_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                clr_s = 1'b0;
                sel_s = 1'b1;
                if (START) begin
                    state_s = CLR_HI;
                    clr_s   = 1'b1;
                    busy_s  = 1'b1;
                    port_s  = 3'd1;
                    cnt_s   = SETTLE_RELOAD;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            CLR_HI: begin
                if (settled_s) begin
                    clr_s   = 1'b0;
                    state_s = CLR_LO;
                    cnt_s   = SETTLE_RELOAD;
                end else begin
                    state_s = CLR_HI;
                end
            end
            CLR_LO, RD_LO: begin
                // SEL falls in the same edge that samples the LDRU nibble.
                if (settled_s) begin
                    cap_lo_s = 1'b1;
                    sel_s    = 1'b0;
                    state_s  = RD_HI;
                    cnt_s    = SETTLE_RELOAD;
                end else begin
                    state_s  = state_r;
                end
            end
            RD_HI: begin
                // SEL rising here is what steps the multitap to its next port.
                if (settled_s) begin
                    cap_hi_s = 1'b1;
                    sel_s    = 1'b1;
                    cnt_s    = SETTLE_RELOAD;
                    if (port_r < LAST_PORT) begin
                        port_s  = port_r + 3'd1;
                        state_s = RD_LO;
                    end else begin
                        state_s = COMMIT;
                    end
                end else begin
                    state_s = RD_HI;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                done_s   = 1'b1;
                busy_s   = 1'b0;
                state_s  = IDLE;
            end
            default: begin
                state_s = IDLE;
                clr_s   = 1'b0;
                sel_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state, settle counter, port index and line/status registers.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            port_r  <= 3'd1;
            clr_r   <= 1'b0;
            sel_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            port_r  <= port_s;
            clr_r   <= clr_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Shadow buffer: nibble captures for the port currently being read.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int n = 0; n < 5; n++) begin
                shadow_r[n] <= 8'hFF;
            end
        end else begin
            if (cap_lo_s) begin
                shadow_r[slot_s][3:0] <= D_IN;
            end
            if (cap_hi_s) begin
                shadow_r[slot_s][7:4] <= D_IN;
            end
        end
    end

    // Published frame: all ports replaced together at COMMIT.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int n = 0; n < 5; n++) begin
                pad_r[n] <= 8'hFF;
            end
        end else if (commit_s) begin
            for (int n = 0; n < 5; n++) begin
                if (n < int'(NUM_PORTS)) begin
                    pad_r[n] <= shadow_r[n];
                end else begin
                    pad_r[n] <= 8'hFF;
                end
            end
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign CLR  = clr_r;
    assign SEL  = sel_r;
    assign PAD1 = pad_r[0];
    assign PAD2 = pad_r[1];
    assign PAD3 = pad_r[2];
    assign PAD4 = pad_r[3];
    assign PAD5 = pad_r[4];

endmodule
